// File: rtl/parity_chk.sv
// Receive-side parity checker: deserializes data_width data bits (LSB first)
// plus one parity bit and flags a mismatch against even/odd parity.
module parity_chk #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chk_start,
  input  logic                  par_typ,
  input  logic                  sampled_bit,
  input  logic                  bit_valid,
  output logic [data_width-1:0] p_data,
  output logic                  par_err,
  output logic                  chk_done,
  output logic                  busy
);

  localparam int CW = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CW-1:0] LAST = CW'(data_width - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  acc_q, acc_d;
  logic                  typ_q, typ_d;
  logic [data_width-1:0] p_data_q, p_data_d;
  logic                  par_err_q, par_err_d;
  logic                  chk_done_q, chk_done_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    typ_d      = typ_q;
    p_data_d   = p_data_q;
    par_err_d  = par_err_q;
    chk_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        // bit_valid is ignored here, even when it coincides with chk_start
        if (chk_start) begin
          state_d   = DATA;
          cnt_d     = '0;
          acc_d     = 1'b0;
          typ_d     = par_typ;
          par_err_d = 1'b0;
        end
      end
      DATA: begin
        if (bit_valid) begin
          p_data_d[cnt_q] = sampled_bit;
          acc_d           = acc_q ^ sampled_bit;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_valid) begin
          par_err_d  = (sampled_bit != (acc_q ^ typ_q));
          chk_done_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // busy is registered alongside state so it stays a flop output
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      typ_q      <= 1'b0;
      p_data_q   <= '0;
      par_err_q  <= 1'b0;
      chk_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      typ_q      <= typ_d;
      p_data_q   <= p_data_d;
      par_err_q  <= par_err_d;
      chk_done_q <= chk_done_d;
      busy_q     <= busy_d;
    end
  end

  assign p_data   = p_data_q;
  assign par_err  = par_err_q;
  assign chk_done = chk_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_parity_chk.sv
// Self-checking bench for parity_chk: directed scenarios plus random frames
// checked against a parity model built from bit counts.
module tb_parity_chk;

  logic       clk = 1'b0;
  logic       rst;
  logic       chk_start;
  logic       par_typ;
  logic       sampled_bit;
  logic       bit_valid;
  logic [7:0] p_data;
  logic       par_err;
  logic       chk_done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  parity_chk #(.data_width(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .chk_start   (chk_start),
    .par_typ     (par_typ),
    .sampled_bit (sampled_bit),
    .bit_valid   (bit_valid),
    .p_data      (p_data),
    .par_err     (par_err),
    .chk_done    (chk_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Error when the total count of ones (data + parity bit) disagrees with the
  // chosen parity: even count required for even parity, odd for odd parity.
  function automatic logic model_err(input logic [7:0] data, input logic typ, input logic pbit);
    int ones;
    ones = $countones(data) + int'(pbit);
    return ((ones % 2) != (typ ? 1 : 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic typ, input logic pbit,
                            input int max_gap, input bit toggle_typ, input bit extra_start,
                            output int stray, output logic busy_mid, output logic done_o,
                            output logic [7:0] pd_o, output logic perr_o, output logic busy_o);
    int g;
    stray     = 0;
    chk_start = 1'b1;
    par_typ   = typ;
    bit_valid = 1'b0;
    tick();
    chk_start = 1'b0;
    busy_mid  = busy;
    if (chk_done) stray++;
    for (int i = 0; i < 9; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
      for (int k = 0; k < g; k++) begin
        sampled_bit = 1'($urandom);
        tick();
        if (chk_done) stray++;
      end
      bit_valid   = 1'b1;
      sampled_bit = (i < 8) ? data[i] : pbit;
      if (extra_start && i == 4) chk_start = 1'b1;
      if (toggle_typ && i == 3) par_typ = ~typ;
      tick();
      bit_valid = 1'b0;
      chk_start = 1'b0;
      if (i < 8 && chk_done) stray++;
    end
    done_o = chk_done;
    pd_o   = p_data;
    perr_o = par_err;
    busy_o = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_start   = 1'($urandom);
      par_typ     = 1'($urandom);
      sampled_bit = 1'($urandom);
      bit_valid   = 1'($urandom);
      tick();
      checks++;
      if ({p_data, par_err, chk_done, busy} !== 11'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%h expected=0", i, {p_data, par_err, chk_done, busy});
      end
    end
    chk_start = 1'b0;
    bit_valid = 1'b0;
    rst       = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      bit_valid   = 1'($urandom);
      sampled_bit = 1'($urandom);
      par_typ     = 1'($urandom);
      tick();
      checks++;
      if (busy !== 1'b0 || chk_done !== 1'b0 || p_data !== 8'h00) begin
        failures++;
        $display("FAIL idle_ignores_bits busy=%b done=%b p_data=%h expected 0/0/00", busy, chk_done, p_data);
      end
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_even_ok();
    int stray; logic bm, d, pe, bo; logic [7:0] pd;
    send_frame(8'b10101001, 1'b0, 1'b0, 0, 0, 0, stray, bm, d, pd, pe, bo);
    checks++;
    if (bm !== 1'b1) begin failures++; $display("FAIL even_ok_busy got=%b expected=1", bm); end
    checks++;
    if (d !== 1'b1 || stray != 0) begin
      failures++; $display("FAIL even_ok_done got=%b stray=%0d expected=1 stray=0", d, stray);
    end
    checks++;
    if (pd !== 8'b10101001 || pe !== model_err(8'b10101001, 1'b0, 1'b0) || bo !== 1'b0) begin
      failures++; $display("FAIL even_ok_data p_data=%b par_err=%b busy=%b expected 10101001/0/0", pd, pe, bo);
    end
    tick();
    checks++;
    if (chk_done !== 1'b0) begin failures++; $display("FAIL even_ok_pulse_width got=%b expected=0", chk_done); end
  endtask

  task automatic test_even_err();
    int stray; logic bm, d, pe, bo; logic [7:0] pd;
    send_frame(8'b10101101, 1'b0, 1'b0, 0, 0, 0, stray, bm, d, pd, pe, bo);
    checks++;
    if (d !== 1'b1 || pd !== 8'b10101101 || pe !== 1'b1 || stray != 0) begin
      failures++;
      $display("FAIL even_err done=%b p_data=%b par_err=%b stray=%0d expected 1/10101101/1/0", d, pd, pe, stray);
    end
    // outputs hold while idle, even with stray bit strobes
    for (int i = 0; i < 5; i++) begin
      bit_valid   = 1'($urandom);
      sampled_bit = 1'($urandom);
      tick();
      checks++;
      if (p_data !== 8'b10101101 || par_err !== 1'b1 || chk_done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL hold p_data=%b par_err=%b done=%b busy=%b expected 10101101/1/0/0", p_data, par_err, chk_done, busy);
      end
    end
    bit_valid = 1'b0;
    chk_start = 1'b1;
    par_typ   = 1'b0;
    tick();
    chk_start = 1'b0;
    checks++;
    if (par_err !== 1'b0 || busy !== 1'b1 || p_data !== 8'b10101101) begin
      failures++;
      $display("FAIL start_clears par_err=%b busy=%b p_data=%b expected 0/1/10101101", par_err, busy, p_data);
    end
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  task automatic test_odd_back_to_back();
    int stray; logic bm, d, pe, bo; logic [7:0] pd;
    send_frame(8'b10101101, 1'b1, 1'b0, 0, 0, 0, stray, bm, d, pd, pe, bo);
    checks++;
    if (d !== 1'b1 || pd !== 8'b10101101 || pe !== 1'b0) begin
      failures++; $display("FAIL odd_ok done=%b p_data=%b par_err=%b expected 1/10101101/0", d, pd, pe);
    end
    // chk_start driven in the chk_done cycle
    send_frame(8'b10101001, 1'b1, 1'b0, 0, 0, 0, stray, bm, d, pd, pe, bo);
    checks++;
    if (bm !== 1'b1 || d !== 1'b1 || pd !== 8'b10101001 || pe !== 1'b1 || stray != 0) begin
      failures++;
      $display("FAIL odd_b2b busy=%b done=%b p_data=%b par_err=%b stray=%0d expected 1/1/10101001/1/0", bm, d, pd, pe, stray);
    end
    tick();
  endtask

  task automatic test_ignored_inputs();
    int stray; logic bm, d, pe, bo; logic [7:0] pd;
    for (int r = 0; r < 3; r++) begin
      send_frame(8'b10101001, 1'b0, 1'b0, 5, 1, 1, stray, bm, d, pd, pe, bo);
      checks++;
      if (d !== 1'b1 || pd !== 8'b10101001 || pe !== 1'b0 || stray != 0 || bo !== 1'b0) begin
        failures++;
        $display("FAIL ignored_inputs run=%0d done=%b p_data=%b par_err=%b stray=%0d busy=%b expected 1/10101001/0/0/0",
                 r, d, pd, pe, stray, bo);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    int stray; int dones; logic bm, d, pe, bo; logic [7:0] pd;
    logic [7:0] v;
    v = 8'b10101001;
    chk_start = 1'b1; par_typ = 1'b1; tick(); chk_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; sampled_bit = v[i]; tick();
    end
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({p_data, par_err, chk_done, busy} !== 11'd0) begin
      failures++; $display("FAIL reset_async got=%h expected=0", {p_data, par_err, chk_done, busy});
    end
    tick();
    rst = 1'b0;
    dones = 0;
    // leftover bits without a new chk_start must be ignored
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; sampled_bit = 1'b1; tick();
      if (chk_done) dones++;
    end
    bit_valid = 1'b0;
    checks++;
    if (dones != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_discard dones=%0d busy=%b expected 0/0", dones, busy);
    end
    send_frame(v, 1'b0, 1'b0, 0, 0, 0, stray, bm, d, pd, pe, bo);
    tick();
    checks++;
    if (d !== 1'b1 || pd !== v || pe !== 1'b0 || stray != 0 || chk_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_recover done=%b p_data=%b par_err=%b stray=%0d after=%b expected 1/10101001/0/0/0",
               d, pd, pe, stray, chk_done);
    end
  endtask

  task automatic test_random_frames();
    int stray; logic bm, d, pe, bo; logic [7:0] pd;
    logic [7:0] v; logic t, p;
    for (int r = 0; r < 20; r++) begin
      v = 8'($urandom);
      t = 1'($urandom);
      p = 1'($urandom);
      send_frame(v, t, p, int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), stray, bm, d, pd, pe, bo);
      checks++;
      if (bm !== 1'b1 || d !== 1'b1 || pd !== v || pe !== model_err(v, t, p) || stray != 0) begin
        failures++;
        $display("FAIL random_frame r=%0d data=%h typ=%b pbit=%b got done=%b p_data=%h par_err=%b stray=%0d expected par_err=%b",
                 r, v, t, p, d, pd, pe, stray, model_err(v, t, p));
      end
      if ($urandom_range(1, 0) == 1) tick();
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; chk_start = 1'b0; par_typ = 1'b0; sampled_bit = 1'b0; bit_valid = 1'b0;
    test_reset();
    test_even_ok();
    test_even_err();
    test_odd_back_to_back();
    test_ignored_inputs();
    test_reset_mid_frame();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
